// File: rtl/mvm_pkg.sv
// Package for the sequential matrix-vector engine.
// Holds the controller state encoding and the helpers that size the
// internal accumulator and the length of the RUN phase.
package mvm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Accumulator wide enough that a full row of DW x DW products cannot overflow.
  function automatic int acc_width(input int dw, input int cols);
    return 2 * dw + $clog2(cols);
  endfunction

  // Number of MAC cycles in one product.
  function automatic int run_cycles(input int rows, input int cols, input int lanes);
    return rows * cols / lanes;
  endfunction

endpackage

// File: rtl/mvm_dot_lane.sv
// Combinational dot-product slice: signed sum of LANES DW x DW products.
// Ports:
//   w_flat  LANES*DW  signed weights, lane l at [l*DW +: DW]
//   x_flat  LANES*DW  signed inputs,  lane l at [l*DW +: DW]
//   sum     OUT_W     signed sum of the lane products
module mvm_dot_lane #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int OUT_W = 18
) (
  input  logic [LANES*DW-1:0]    w_flat,
  input  logic [LANES*DW-1:0]    x_flat,
  output logic signed [OUT_W-1:0] sum
);

  logic signed [2*DW-1:0] prod;

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      prod = $signed(w_flat[l*DW +: DW]) * $signed(x_flat[l*DW +: DW]);
      sum  = sum + OUT_W'(prod);
    end
  end

endmodule

// File: rtl/mvm_seq_engine.sv
// Sequential matrix-vector multiply engine.
// A ROWS x COLS signed weight matrix is preloaded while idle; start latches an
// input vector and the engine walks the matrix row-major, LANES columns per
// cycle, producing one saturated or wrapped result per row with overflow flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   preload_valid/addr/data  weight write ({row, col} address), IDLE only
//   start, x_vector_flat, sat_en  begin a product (vector and mode latched)
//   busy, done          status; done is a one-cycle pulse with final results
//   result_flat, ovf_flat  per-row results and overflow flags
module mvm_seq_engine
  import mvm_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROWS  = 40,
  parameter int COLS  = 40,
  parameter int ROW_W = 7,
  parameter int COL_W = 7,
  parameter int ACC_W = 16,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     preload_valid,
  input  logic [ROW_W+COL_W-1:0]   preload_addr,
  input  logic [DW-1:0]            preload_data,
  input  logic                     start,
  input  logic [COLS*DW-1:0]       x_vector_flat,
  input  logic                     sat_en,
  output logic                     busy,
  output logic                     done,
  output logic [ROWS*ACC_W-1:0]    result_flat,
  output logic [ROWS-1:0]          ovf_flat
);

  localparam int AW     = acc_width(DW, COLS);
  localparam int N      = run_cycles(ROWS, COLS, LANES);
  localparam int GROUPS = COLS / LANES;
  localparam int RC_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CI_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int GC_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int SW     = (N > 1) ? $clog2(N) : 1;
  localparam int EW     = (AW > ACC_W) ? AW : ACC_W;

  localparam logic signed [EW-1:0] RES_MAX = (EW'(1) <<< (ACC_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] RES_MIN = -(EW'(1) <<< (ACC_W - 1));

  if (COLS % LANES != 0) begin : g_bad_lanes
    $error("mvm_seq_engine: COLS must be a multiple of LANES");
  end

  state_t state_q, state_d;

  logic [DW-1:0]          weight [ROWS][COLS];
  logic [COLS*DW-1:0]     x_q;
  logic                   sat_q;
  logic [RC_W-1:0]        row_q;
  logic [GC_W-1:0]        grp_q;
  logic [SW-1:0]          step_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW-1:0]   dot;

  // Finished-row staging: a row's result lands one cycle after its last MAC,
  // letting the accumulator restart for the next row without a bubble.
  logic                   fin_v_q;
  logic [RC_W-1:0]        fin_row_q;
  logic signed [AW-1:0]   fin_acc_q;
  logic signed [EW-1:0]   fin_ext;
  logic [ACC_W-1:0]       row_res;
  logic                   row_ovf;

  logic [LANES*DW-1:0]    w_lane;
  logic [LANES*DW-1:0]    x_lane;
  logic [ROW_W-1:0]       p_row;
  logic [COL_W-1:0]       p_col;
  logic                   p_hit;

  assign p_row = preload_addr[ROW_W+COL_W-1 -: ROW_W];
  assign p_col = preload_addr[COL_W-1:0];
  // Range check before truncating the address so out-of-range rows/cols never alias.
  assign p_hit = preload_valid && (state_q == S_IDLE) &&
                 (32'(p_row) < ROWS) && (32'(p_col) < COLS);

  always_ff @(posedge clk) begin
    if (p_hit) begin
      weight[RC_W'(p_row)][CI_W'(p_col)] <= preload_data;
    end
  end

  always_comb begin
    w_lane = '0;
    x_lane = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane[l*DW +: DW] = weight[row_q][CI_W'(32'(grp_q) * LANES + l)];
      x_lane[l*DW +: DW] = x_q[(32'(grp_q) * LANES + l) * DW +: DW];
    end
  end

  mvm_dot_lane #(
    .DW    (DW),
    .LANES (LANES),
    .OUT_W (AW)
  ) u_dot (
    .w_flat (w_lane),
    .x_flat (x_lane),
    .sum    (dot)
  );

  assign acc_sum = acc_q + dot;

  always_comb begin
    fin_ext = EW'(fin_acc_q);
    row_ovf = (fin_ext > RES_MAX) || (fin_ext < RES_MIN);
    row_res = fin_ext[ACC_W-1:0];
    if (sat_q && (fin_ext > RES_MAX)) begin
      row_res = RES_MAX[ACC_W-1:0];
    end else if (sat_q && (fin_ext < RES_MIN)) begin
      row_res = RES_MIN[ACC_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (step_q == SW'(N - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      x_q         <= '0;
      sat_q       <= 1'b0;
      row_q       <= '0;
      grp_q       <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      fin_v_q     <= 1'b0;
      fin_row_q   <= '0;
      fin_acc_q   <= '0;
      result_flat <= '0;
      ovf_flat    <= '0;
    end else begin
      state_q <= state_d;
      // Status flags are registered from the state, so they trail it by one cycle.
      busy    <= (state_q == S_RUN);
      done    <= (state_q == S_DONE);
      fin_v_q <= 1'b0;

      if ((state_q == S_IDLE) && start) begin
        x_q    <= x_vector_flat;
        sat_q  <= sat_en;
        row_q  <= '0;
        grp_q  <= '0;
        step_q <= '0;
        acc_q  <= '0;
      end

      if (state_q == S_RUN) begin
        step_q <= step_q + 1'b1;
        if (grp_q == GC_W'(GROUPS - 1)) begin
          grp_q     <= '0;
          acc_q     <= '0;
          fin_v_q   <= 1'b1;
          fin_row_q <= row_q;
          fin_acc_q <= acc_sum;
          row_q     <= (row_q == RC_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
          grp_q <= grp_q + 1'b1;
          acc_q <= acc_sum;
        end
      end

      if (fin_v_q) begin
        result_flat[fin_row_q*ACC_W +: ACC_W] <= row_res;
        ovf_flat[fin_row_q]                   <= row_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mvm_seq_engine.sv
module tb_mvm_seq_engine;

  localparam int DW    = 8;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ROW_W = 7;
  localparam int COL_W = 7;
  localparam int ACC_W = 16;
  localparam int LANES = 2;
  localparam int N     = ROWS * COLS / LANES;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   preload_valid;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0]          preload_data;
  logic                   start;
  logic [COLS*DW-1:0]     x_vector_flat;
  logic                   sat_en;
  logic                   busy;
  logic                   done;
  logic [ROWS*ACC_W-1:0]  result_flat;
  logic [ROWS-1:0]        ovf_flat;

  always #5 clk = ~clk;

  mvm_seq_engine #(
    .DW    (DW),
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .ACC_W (ACC_W),
    .LANES (LANES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .preload_valid (preload_valid),
    .preload_addr  (preload_addr),
    .preload_data  (preload_data),
    .start         (start),
    .x_vector_flat (x_vector_flat),
    .sat_en        (sat_en),
    .busy          (busy),
    .done          (done),
    .result_flat   (result_flat),
    .ovf_flat      (ovf_flat)
  );

  typedef struct {
    logic [ROWS*ACC_W-1:0] res;
    logic [ROWS-1:0]       ovf;
  } exp_t;

  exp_t sb[$];
  int   w_m [ROWS][COLS];
  int   x_m [COLS];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input bit sat);
    exp_t   e;
    longint acc;
    longint lim;
    lim = longint'(1) <<< (ACC_W - 1);
    for (int r = 0; r < ROWS; r++) begin
      acc = 0;
      for (int c = 0; c < COLS; c++) acc += longint'(w_m[r][c]) * longint'(x_m[c]);
      e.ovf[r] = (acc > lim - 1) || (acc < -lim);
      if (sat && acc > lim - 1)   acc = lim - 1;
      else if (sat && acc < -lim) acc = -lim;
      e.res[r*ACC_W +: ACC_W] = acc[ACC_W-1:0];
    end
    return e;
  endfunction

  task automatic preload(input int r, input int c, input int v);
    preload_valid = 1'b1;
    preload_addr  = {ROW_W'(r), COL_W'(c)};
    preload_data  = DW'(v);
    @(posedge clk); #1;
    preload_valid = 1'b0;
    if (r < ROWS && c < COLS) w_m[r][c] = v;
  endtask

  task automatic fill_rc();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) preload(r, c, r + c);
  endtask

  task automatic fill_all(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) preload(r, c, v);
  endtask

  // disturb: start and a preload during RUN; abort_at: reset pulse at that cycle.
  task automatic run(input string tag, input bit sat, input bit disturb, input int abort_at);
    exp_t e;
    int   cyc;
    bit   seen;
    sb.push_back(model(sat));
    for (int c = 0; c < COLS; c++) x_vector_flat[c*DW +: DW] = DW'(x_m[c]);
    sat_en = sat;
    start  = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    preload_valid = 1'b0;
    sat_en        = ~sat;
    x_vector_flat = $urandom();
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, longint'(busy), 1);
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_busy"}, longint'(busy), 0);
        check({tag, "_rst_done"}, longint'(done), 0);
        check({tag, "_rst_res"}, longint'(result_flat != '0), 0);
        check({tag, "_rst_ovf"}, longint'(ovf_flat), 0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (disturb && cyc == 3) begin
        start         = 1'b1;
        sat_en        = ~sat;
        preload_valid = 1'b1;
        preload_addr  = {ROW_W'(3), COL_W'(3)};
        preload_data  = 8'd99;
      end
      if (disturb && cyc == 4) begin
        start         = 1'b0;
        preload_valid = 1'b0;
      end
      seen = done;
    end
    check({tag, "_done_cycle"}, longint'(cyc), N + 1);
    e = sb.pop_front();
    if (seen) begin
      for (int r = 0; r < ROWS; r++) begin
        check($sformatf("%s_res%0d", tag, r),
              longint'($signed(result_flat[r*ACC_W +: ACC_W])),
              longint'($signed(e.res[r*ACC_W +: ACC_W])));
      end
      check({tag, "_ovf"}, longint'(ovf_flat), longint'(e.ovf));
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, longint'(done), 0);
      check({tag, "_busy_end"}, longint'(busy), 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    preload_valid = 1'b0;
    preload_addr  = '0;
    preload_data  = '0;
    start         = 1'b0;
    x_vector_flat = '0;
    sat_en        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_res", longint'(result_flat != '0), 0);
    check("reset_ovf", longint'(ovf_flat), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // w[r][c] = r+c, x = 4-c -> 10, 20, 30, 40
    fill_rc();
    x_m = '{4, 3, 2, 1};
    run("basic", 1'b1, 1'b0, 0);

    // Large positive accumulator: saturate and wrap
    fill_all(127);
    x_m = '{127, 127, 127, 127};
    run("sat_pos", 1'b1, 1'b0, 0);
    run("wrap_pos", 1'b0, 1'b0, 0);

    // All -128; the final weight write coincides with start
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == 3 && c == 3)) preload(r, c, -128);
    preload_valid = 1'b1;
    preload_addr  = {ROW_W'(3), COL_W'(3)};
    preload_data  = 8'h80;
    w_m[3][3]     = -128;
    run("sat_neg", 1'b1, 1'b0, 0);

    // Mixed signs with start/preload activity during RUN
    fill_rc();
    x_m = '{-3, 5, 7, -2};
    run("disturb", 1'b0, 1'b1, 0);
    run("after_disturb", 1'b0, 1'b0, 0);

    // Out-of-range preloads must not alias into the matrix
    preload(5, 0, 77);
    preload(1, 6, 55);
    run("oob", 1'b1, 1'b0, 0);

    // Reset mid-RUN, then a normal product
    run("abort", 1'b1, 1'b0, 4);
    fill_rc();
    x_m = '{4, 3, 2, 1};
    run("post_reset", 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_seq_engine.md
MVM_SEQ_ENGINE -- requirements
Module: mvm_seq_engine

Interface
REQ-001 Parameter DW, default 8, signed weight/input element width.
REQ-002 Parameter ROWS, default 40, matrix rows / result count.
REQ-003 Parameter COLS, default 40, matrix columns / input vector length.
REQ-004 Parameter ROW_W, default 7, row-address width; COL_W, default 7, column-address width.
REQ-005 Parameter ACC_W, default 16, signed result width.
REQ-006 Parameter LANES, default 4, MACs per cycle. COLS SHALL be a multiple of LANES; violation is an elaboration error.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 preload_valid  in  1  weight write strobe.
REQ-010 preload_addr  in  ROW_W+COL_W  {row, col} weight address.
REQ-011 preload_data  in  DW  signed weight.
REQ-012 start  in  1  begin one matrix-vector product.
REQ-013 x_vector_flat  in  COLS*DW  signed vector; element c at [c*DW +: DW].
REQ-014 sat_en  in  1  1 = saturate results, 0 = two's-complement wrap; sampled with start.
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle pulse when result_flat is final.
REQ-017 result_flat  out  ROWS*ACC_W  signed results; row r at [r*ACC_W +: ACC_W].
REQ-018 ovf_flat  out  ROWS  per-row overflow flag for the last product.

Function
REQ-019 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last MAC cycle; DONE->IDLE unconditionally after one cycle.
REQ-020 In IDLE, preload_valid=1 writes preload_data to weight[row][col]; row>=ROWS or col>=COLS is silently dropped.
REQ-021 preload_valid in RUN or DONE is ignored, with no write.
REQ-022 start in IDLE latches x_vector_flat and sat_en into internal registers; start in RUN or DONE is ignored.
REQ-023 If start and preload_valid are both high in IDLE, the write completes and the product uses the updated matrix.
REQ-024 RUN lasts exactly N=ROWS*COLS/LANES cycles; each cycle processes LANES consecutive columns of one row, row-major.
REQ-025 Per row, accumulate in a signed internal accumulator of 2*DW+clog2(COLS) bits, so no internal overflow.
REQ-026 At row end, result = acc clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1] if sat_en, else acc[ACC_W-1:0].
REQ-027 ovf bit = 1 when acc lies outside the ACC_W range, regardless of sat_en.
REQ-028 A row's result and ovf bit are written the cycle after that row's final MAC; all rows are final when done=1.
REQ-029 Timing: start sampled at edge k gives busy=1 after edge k+1, and done=1 after edge k+N+1, for exactly one cycle.
REQ-030 result_flat and ovf_flat hold their values until the next accepted start completes rows, and are overwritten row by row.

Reset
REQ-031 On rst_n low: state=IDLE, busy=0, done=0, result_flat=0, ovf_flat=0, counters=0, latched x=0, latched sat_en=0.
REQ-032 Weight memory is not reset; its contents are undefined until preloaded.
REQ-033 Reset during RUN aborts the product; after reset release the block accepts preload and start normally.

Structure
REQ-034 Package mvm_pkg holds the state enum and helper localparams (accumulator width, N).
REQ-035 One sub-module, mvm_dot_lane, is combinational and returns the signed sum of LANES DW x DW products.

Verification
Use ROWS=COLS=4 and LANES=2 unless stated otherwise.
REQ-036 Preload w[r][c]=r+c, x[c]=4-c, sat_en=1, start -> results 10, 20, 30, 40; ovf=0; done exactly 9 cycles after start sampled.
REQ-037 All w=127, all x=127 -> each acc is 64516; sat_en=1 gives 32767 and ovf=1; sat_en=0 gives -1020 and ovf=1.
REQ-038 All w=-128, all x=127, sat_en=1 -> each result -32768, ovf=1.
REQ-039 A second start mid-RUN, and preload writes mid-RUN -> both ignored; results match a run without them.
REQ-040 rst_n pulsed low mid-RUN -> outputs zero; busy=0; after re-preload and start, correct results as in REQ-036.
REQ-041 Preload to row=5 (out of range) in IDLE -> no aliasing write; results unchanged.
